// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: forward-select codes,
// the PC register number and the shadow stage-tag record.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int PC_REG = 15;

  // Tag register-number field is sized for the widest core we build; narrower
  // register files zero-extend into it.
  localparam int TAG_AW_MAX = 8;

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic                  pcsrc;
    logic [TAG_AW_MAX-1:0] wa;
  } stage_tag_t;

endpackage

// File: rtl/hazard_tag_stage.sv
// One shadow pipeline tag register: hold keeps the current tag, bubble loads
// all-zero, otherwise the upstream tag is captured.
module hazard_tag_stage
  import hazard_pkg::*;
#(
  parameter int W = $bits(stage_tag_t)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] tag_q;
  logic [W-1:0] tag_d;

  always_comb begin
    tag_d = d_i;
    if (hold_i)        tag_d = tag_q;
    else if (bubble_i) tag_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  assign q_o = tag_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit with shadow E/M/W destination tags, multi-cycle EX
// handshake and PC-write tracking. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*REG_AW-1:0] ra_d,
  input  logic [NSRC-1:0]        rv_d,
  input  logic [REG_AW-1:0]      wa_d,
  input  logic                   regwrite_d,
  input  logic                   memtoreg_d,
  input  logic                   pcsrc_d,
  input  logic                   branch_taken_e,
  input  logic                   ex_busy,
  output logic [NSRC*2-1:0]      fwd_e,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_e,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_cycles
);

  localparam int TAG_W = $bits(stage_tag_t);
  localparam int E_W   = TAG_W + NSRC*REG_AW + NSRC;

  stage_tag_t               tag_in_d;
  stage_tag_t               tag_e;
  stage_tag_t               tag_m;
  stage_tag_t               tag_w;
  logic [E_W-1:0]           e_q;
  logic [NSRC*REG_AW-1:0]   ra_e;
  logic [NSRC-1:0]          rv_e;
  logic                     ld_match;
  logic                     ldrstall;
  logic                     pcwp;
  logic                     stall_e_raw;
  logic                     flush_e_raw;
  logic                     unused_memtoreg;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] ra,
                                         input logic              rv,
                                         input stage_tag_t        m,
                                         input stage_tag_t        w);
    logic [TAG_AW_MAX-1:0] ra_x;
    ra_x = TAG_AW_MAX'(ra);
    if (!rv || ra == REG_AW'(PC_REG)) return FWD_RF;
    if (m.regwrite && m.wa == ra_x)   return FWD_M;
    if (w.regwrite && w.wa == ra_x)   return FWD_W;
    return FWD_RF;
  endfunction

  assign tag_in_d = '{regwrite: regwrite_d, memtoreg: memtoreg_d,
                      pcsrc: pcsrc_d, wa: TAG_AW_MAX'(wa_d)};

  // E carries source operands too so forwarding can be computed from the tag alone.
  hazard_tag_stage #(.W(E_W)) u_tag_e (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (stall_e_raw),
    .bubble_i (flush_e_raw),
    .d_i      ({tag_in_d, ra_d, rv_d}),
    .q_o      (e_q)
  );

  assign tag_e = e_q[E_W-1 -: TAG_W];
  assign ra_e  = e_q[NSRC +: NSRC*REG_AW];
  assign rv_e  = e_q[NSRC-1:0];

  hazard_tag_stage #(.W(TAG_W)) u_tag_m (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (1'b0),
    .bubble_i (stall_e_raw),
    .d_i      (tag_e),
    .q_o      (tag_m)
  );

  hazard_tag_stage #(.W(TAG_W)) u_tag_w (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (1'b0),
    .bubble_i (1'b0),
    .d_i      (tag_m),
    .q_o      (tag_w)
  );

  always_comb begin
    ld_match = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (rv_d[i] && TAG_AW_MAX'(ra_d[i*REG_AW +: REG_AW]) == tag_e.wa) ld_match = 1'b1;
    end
  end

  assign ldrstall    = tag_e.regwrite & tag_e.memtoreg & ld_match;
  assign pcwp        = pcsrc_d | tag_e.pcsrc | tag_m.pcsrc;
  assign stall_e_raw = ex_busy;
  // A busy EX unit owns E, so a coincident branch or load-use flush is dropped.
  assign flush_e_raw = (ldrstall | branch_taken_e) & ~ex_busy;

  assign stall_f = ~reset & (ldrstall | pcwp | ex_busy);
  assign stall_d = ~reset & (ldrstall | ex_busy);
  assign stall_e = ~reset & stall_e_raw;
  assign flush_d = ~reset & (pcwp | tag_w.pcsrc | (branch_taken_e & ~ex_busy));
  assign flush_e = ~reset & flush_e_raw;

  always_comb begin
    fwd_e = '0;
    if (!reset) begin
      for (int i = 0; i < NSRC; i++) begin
        fwd_e[i*2 +: 2] = fwd_sel(ra_e[i*REG_AW +: REG_AW], rv_e[i], tag_m, tag_w);
      end
    end
  end

  assign unused_memtoreg = tag_m.memtoreg ^ tag_w.memtoreg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && v != '1) return v + CNT_W'(1);
    return v;
  endfunction

  assign stall_cnt_d = sat_inc(stall_cnt_q, stall_d);
  assign flush_cnt_d = sat_inc(flush_cnt_q, flush_e);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus reset and
// performance-counter sequences.
module tb_hazard_scoreboard;

  localparam int NSRC   = 3;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 2;
  localparam int NVEC   = 37;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NSRC*REG_AW-1:0] ra_d;
  logic [NSRC-1:0]        rv_d;
  logic [REG_AW-1:0]      wa_d;
  logic                   regwrite_d, memtoreg_d, pcsrc_d, branch_taken_e, ex_busy;
  logic [NSRC*2-1:0]      fwd_e;
  logic                   stall_f, stall_d, stall_e, flush_d, flush_e;
  logic [CNT_W-1:0]       stall_cycles, flush_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [11:0] ra;
    logic [2:0]  rv;
    logic [3:0]  wa;
    logic        rw, mr, pc, bt, bz;
    logic [5:0]  fwd;
    logic [4:0]  flg;   // {stall_f, stall_d, stall_e, flush_d, flush_e}
  } vec_t;

  vec_t tbl [NVEC];

  hazard_scoreboard #(.NSRC(NSRC), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ra_d           (ra_d),
    .rv_d           (rv_d),
    .wa_d           (wa_d),
    .regwrite_d     (regwrite_d),
    .memtoreg_d     (memtoreg_d),
    .pcsrc_d        (pcsrc_d),
    .branch_taken_e (branch_taken_e),
    .ex_busy        (ex_busy),
    .fwd_e          (fwd_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int ra2, int ra1, int ra0, logic [2:0] rv, int wa,
                              logic rw, logic mr, logic pc, logic bt, logic bz,
                              logic [5:0] fwd, logic [4:0] flg);
    vec_t v;
    v.ra  = {4'(ra2), 4'(ra1), 4'(ra0)};
    v.rv  = rv;
    v.wa  = 4'(wa);
    v.rw  = rw; v.mr = mr; v.pc = pc; v.bt = bt; v.bz = bz;
    v.fwd = fwd;
    v.flg = flg;
    return v;
  endfunction

  task automatic drv(input vec_t v);
    ra_d = v.ra; rv_d = v.rv; wa_d = v.wa;
    regwrite_d = v.rw; memtoreg_d = v.mr; pcsrc_d = v.pc;
    branch_taken_e = v.bt; ex_busy = v.bz;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {fwd_e, stall_f, stall_d, stall_e, flush_d, flush_e};
  endfunction

  vec_t nop;

  initial begin
    nop = mk(0,0,0, 3'b000, 0, 0,0,0,0,0, 6'b0, 5'b0);

    // ADD r1 in M forwards to SUB in E (operand 0)
    tbl[0]  = mk(0,0,0, 3'b000, 1, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[1]  = mk(0,0,1, 3'b001, 6, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[2]  = nop; tbl[2].fwd = 6'b000010;
    tbl[3]  = nop;
    // LDR r2 then consumer of r2 on operand 1: one-cycle stall, then W forward
    tbl[4]  = mk(0,0,0, 3'b000, 2, 1,1,0,0,0, 6'b000000, 5'b00000);
    tbl[5]  = mk(0,2,0, 3'b010, 7, 1,0,0,0,0, 6'b000000, 5'b11001);
    tbl[6]  = mk(0,2,0, 3'b010, 7, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[7]  = nop; tbl[7].fwd = 6'b000100;
    tbl[8]  = nop;
    tbl[9]  = nop;
    // r3 in both M and W: M wins; then r15 in M never forwards
    tbl[10] = mk(0,0,0, 3'b000, 3, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[11] = mk(0,0,0, 3'b000, 3, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[12] = mk(3,0,0, 3'b100, 8, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[13] = nop; tbl[13].fwd = 6'b100000;
    tbl[14] = mk(0,0,0, 3'b000, 15, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[15] = mk(0,0,15, 3'b001, 0, 0,0,0,0,0, 6'b000000, 5'b00000);
    tbl[16] = nop;
    tbl[17] = nop;
    tbl[18] = nop;
    // PC write in D: stall_f 3 cycles, flush_d 4 cycles
    tbl[19] = mk(0,0,0, 3'b000, 15, 1,0,1,0,0, 6'b000000, 5'b10010);
    tbl[20] = nop; tbl[20].flg = 5'b10010;
    tbl[21] = nop; tbl[21].flg = 5'b10010;
    tbl[22] = nop; tbl[22].flg = 5'b00010;
    tbl[23] = nop;
    // ex_busy 3 cycles: ADD r4 in M, LDR r5 (reads r4) in E, consumer of r5 in D
    tbl[24] = mk(0,0,0, 3'b000, 4, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[25] = mk(0,0,4, 3'b001, 5, 1,1,0,0,0, 6'b000000, 5'b00000);
    tbl[26] = mk(0,5,0, 3'b010, 9, 1,0,0,0,1, 6'b000010, 5'b11100);
    tbl[27] = mk(0,5,0, 3'b010, 9, 1,0,0,0,1, 6'b000001, 5'b11100);
    tbl[28] = mk(0,5,0, 3'b010, 9, 1,0,0,0,1, 6'b000000, 5'b11100);
    tbl[29] = mk(0,5,0, 3'b010, 9, 1,0,0,0,0, 6'b000000, 5'b11001);
    tbl[30] = mk(0,5,0, 3'b010, 9, 1,0,0,0,0, 6'b000000, 5'b00000);
    tbl[31] = nop; tbl[31].fwd = 6'b000100;
    tbl[32] = nop;
    tbl[33] = nop;
    // Branch taken, then branch coincident with busy (busy wins)
    tbl[34] = mk(0,0,0, 3'b000, 0, 0,0,0,1,0, 6'b000000, 5'b00011);
    tbl[35] = mk(0,0,0, 3'b000, 0, 0,0,0,1,1, 6'b000000, 5'b11100);
    tbl[36] = nop;

    // Reset state: outputs forced low even with hazard-causing inputs
    drv(nop);
    pcsrc_d = 1'b1;
    ex_busy = 1'b1;
    reset   = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'(outs()), 32'h0);
    chk("reset_counters", 32'({stall_cycles, flush_cycles}), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drv(tbl[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'({tbl[i].fwd, tbl[i].flg}));
      tick();
    end

    // Performance counters: 5 busy stall cycles saturate a 2-bit counter
    drv(nop);
    reset = 1'b1;
    #2;
    chk("cnt_clear", 32'({stall_cycles, flush_cycles}), 32'h0);
    tick();
    reset   = 1'b0;
    ex_busy = 1'b1;
    tick();
    tick();
    chk("stall_cnt_2", 32'(stall_cycles), PERF ? 32'd2 : 32'd0);
    tick();
    tick();
    tick();
    chk("stall_cnt_sat", 32'(stall_cycles), PERF ? 32'd3 : 32'd0);
    chk("flush_cnt_busy", 32'(flush_cycles), 32'd0);
    ex_busy        = 1'b0;
    branch_taken_e = 1'b1;
    tick();
    branch_taken_e = 1'b0;
    #1;
    chk("flush_cnt_1", 32'(flush_cycles), PERF ? 32'd1 : 32'd0);

    // Mid-stream reset drops the in-flight load tag
    drv(mk(0,0,0, 3'b000, 2, 1,1,0,0,0, 6'b0, 5'b0));
    tick();
    drv(mk(0,0,2, 3'b001, 7, 1,0,0,0,0, 6'b0, 5'b0));
    #2;
    chk("pre_reset_ldrstall", 32'(outs()), 32'b11001);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(outs()), 32'h0);
    chk("async_reset_counters", 32'({stall_cycles, flush_cycles}), 32'h0);
    tick();
    reset = 1'b0;
    #2;
    chk("post_reset_first", 32'(outs()), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the 5-stage pipelined ARM core, the successor to the current `hazard` block. It keeps its own shadow copy of destination-register tags for E/M/W instead of taking precomputed match strobes from the datapath. It supports NSRC source operands, a multi-cycle execute unit with a busy handshake, and PC-write tracking. It sits beside `controller` and `datapath` in `arm`, driving forward selects, stalls and flushes.

## Interface
- NSRC, 3, source operands per instruction (Rn, Rm, Rs/Rd-for-store)
- REG_AW, 4, register-number width
- CNT_W, 16, performance-counter width
- clk  in  1  core clock
- reset  in  1  reset; asynchronous and active-high
- ra_d  in  NSRC*REG_AW  source register numbers of the instruction in D
- rv_d  in  NSRC  per-source valid (operand actually read)
- wa_d  in  REG_AW  destination register of the instruction in D
- regwrite_d, memtoreg_d, pcsrc_d  in  1 each  D-stage control (pcsrc_d = instruction writes R15)
- branch_taken_e  in  1  branch resolved taken in E
- ex_busy  in  1  multi-cycle EX unit holding E
- fwd_e  out  NSRC*2  per operand: 00 register file, 01 W result, 10 M result
- stall_f, stall_d, stall_e, flush_d, flush_e  out  1 each
- stall_cycles, flush_cycles  out  CNT_W each  performance counters

## Operation
- Shadow stage tags for E, M and W, each holding {regwrite, memtoreg, pcsrc, wa}. E additionally holds ra/rv.
- Tag advance on each clk:
  - E: holds if stall_e. Otherwise loads a bubble (all zero) if flush_e. Otherwise loads the D inputs.
  - M: loads a bubble if stall_e, else loads E.
  - W: always loads M.
- Forwarding for operand i:
  - fwd_e[i] = 10 if rv_e[i] & regwrite_m & wa_m==ra_e[i].
  - Else 01 if the same match holds for W.
  - Else 00.
  - M takes priority over W.
  - ra==15 never forwards; it always selects 00.
- Load-use stall: ldrstall = regwrite_e & memtoreg_e & (any i: rv_d[i] & ra_d[i]==wa_e).
- PC-write pending: pcwp = pcsrc_d | pcsrc_e | pcsrc_m.
- Output equations:
  - stall_f = ldrstall | pcwp | ex_busy
  - stall_d = ldrstall | ex_busy
  - stall_e = ex_busy
  - flush_d = pcwp | pcsrc_w | (branch_taken_e & ~ex_busy)
  - flush_e = (ldrstall | branch_taken_e) & ~ex_busy
- ex_busy and branch_taken_e are mutually exclusive by construction. If both are high, ex_busy wins and the branch is ignored that cycle.
- The datapath applies flush over stall on the D register. This block does not resolve that conflict.

## Timing
- All outputs are combinational from the tags and the current inputs. Tags update on the rising edge of clk.
- Reset clears all tags and counters immediately. While reset is high, every output is forced to 0.
- Reset mid-stream drops all in-flight tags. There are no stalls or flushes on the first cycle after release.
- A load-use hazard stalls for exactly 1 cycle. On the next cycle the consumer in E sees fwd 01.
- A PC write in D causes:
  - stall_f for 3 cycles (D, E, M).
  - flush_d for 4 cycles (through W).
- While ex_busy is high, M receives bubbles every cycle: regwrite_m=0 from the second busy cycle onward.
- Forwarding from W covers the write-back-before-read case. There is no separate RF bypass.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments each cycle stall_d=1.
  - flush_cycles increments each cycle flush_e=1.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: both counter ports exist and are tied to 0, with no counter logic.

## Structure
- Package hazard_pkg holds:
  - fwd select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - PC_REG=15
  - the stage-tag struct type
- Sub-module hazard_tag_stage is one shadow tag register with hold and bubble controls. It is instantiated for E, M and W.

## Test plan
- ADD r1 in M, SUB in E reads r1 as operand 0 -> fwd_e[1:0]=10. No stalls.
- LDR r2 in E, D reads r2 -> stall_f=stall_d=flush_e=1 for one cycle. Next cycle fwd_e=01 for that operand.
- r3 written by both M and W, E reads r3 -> fwd 10 (M priority). An E read of r15 with r15 written in M -> fwd 00.
- pcsrc_d pulse for one cycle -> stall_f high for 3 cycles, flush_d high for 4 cycles, then both 0.
- ex_busy high 3 cycles with a dependent instruction in D:
  - stall_e=stall_d=stall_f=1 and flush_e=0 throughout.
  - regwrite_m=0 from busy cycle 2.
  - The E tag is unchanged after busy drops.
- HAZARD_PERF_CNT_EN with CNT_W=2, 5 stall cycles -> stall_cycles saturates at 3. Assert reset mid-run -> all counters and outputs 0 immediately.
